led_fade_driver: RTL and testbench
==================================

// Module: led_fade_driver
// PURPOSE
//   Downstream stage of the 4-LED water-light chain. Consumes the active-low 4-bit LED pattern
//   and drives the board LEDs with PWM, so each LED fades in/out linearly instead of switching hard.
//   Pure same-clock-domain post-processor; adds a per-channel fade engine and a shared PWM timebase.
// PARAMETERS
//   PWM_BITS      4'd8           PWM resolution; period = 2**PWM_BITS clocks, duty range 0..2**PWM_BITS-1
//   STEP_CNT_MAX  17'd97_655     step_cnt wrap value; one duty step every STEP_CNT_MAX+1 clocks (~0.5 s full fade @50 MHz, 8 bit)
// PORTS
//   sys_clk    in   1         system clock
//   sys_rst_n  in   1         asynchronous active-low reset
//   led_in     in   4         target pattern, active-low (0 = LED should be lit)
//   led_out    out  4         PWM LED drive, active-low, registered
//   fade_busy  out  1         1 while any channel is RISING or FALLING
// BEHAVIOUR
//   Clock sys_clk; reset sys_rst_n, asynchronous, active-low.
//   Reset values: led_out=4'b1111, fade_busy=0, all duty/duty_act=0, pwm_cnt=0, step_cnt=0,
//     led_in_r=4'b1111, every channel in OFF.
//   led_in registered once into led_in_r; target_on[i] = ~led_in_r[i].
//   pwm_cnt: free-running 0..2**PWM_BITS-1, wraps to 0; pwm_wrap = (pwm_cnt == max).
//   step_cnt: counts 0..STEP_CNT_MAX, wraps to 0; step_tick is a 1-cycle pulse when step_cnt==STEP_CNT_MAX.
//   Per-channel FSM (OFF, RISING, ON, FALLING), evaluated every cycle:
//     OFF     : target_on -> RISING
//     RISING  : !target_on -> FALLING (reverse from current duty, no jump);
//               step_tick & duty==max -> ON; else step_tick -> duty+1
//     ON      : !target_on -> FALLING
//     FALLING : target_on -> RISING; step_tick & duty==0 -> OFF; else step_tick -> duty-1
//   Duty saturates at 0 and max; never wraps. Reversal and step in the same cycle: direction wins, no step that cycle.
//   duty_act[i] <= duty[i] only when pwm_wrap (glitch-free duty update, whole PWM periods only).
//   led_out[i] <= ~(duty_act==max | pwm_cnt < compare), compare = duty_act (see CONFIGURATION).
//     duty_act==0 -> LED fully off; duty_act==max -> LED fully on (forced, no 1-clock gap).
//   Latency: led_in edge -> FSM leaves OFF/ON 2 clocks later; first duty change on next step_tick;
//     visible at led_out after next pwm_wrap + 1 clock.
//   fade_busy registered: OR of (state==RISING|FALLING) over channels, 1 clock behind the FSM.
//   Reset mid-fade: all channels return to OFF/duty 0 immediately; no memory of the prior pattern.
//   led_in toggling faster than a fade: channel oscillates around current duty, never glitches.
// CONFIGURATION
//   LED_GAMMA_EN defined : compare = (duty_act*duty_act) >> PWM_BITS (2*PWM_BITS-bit product, then truncate);
//     perceptual fade; max duty is still forced fully on.
//   LED_GAMMA_EN undefined : compare = duty_act (linear). Ports/timing identical in both builds.
// STRUCTURE
//   Shared package led_pkg: FSM state encoding (2-bit OFF=0, RISING=1, ON=2, FALLING=3), LED_NUM=4 constant.
//   Sub-module led_fade_channel: one FSM + duty + duty_act + compare/output bit; instantiated LED_NUM times.
//   Top holds led_in_r, pwm_cnt, step_cnt/step_tick, fade_busy reduction.
// TESTING (bench overrides PWM_BITS=4, STEP_CNT_MAX=3: step every 4 clocks, PWM period 16)
//   Reset, led_in=4'b1111 held -> led_out=4'b1111, fade_busy=0 for 200 clocks.
//   led_in=4'b1110 from reset -> ch0 duty 0->15 in 15 step_ticks (~60 clocks), fade_busy 1 then 0;
//     finally led_out[0]=0 constant, led_out[3:1]=1.
//   ch0 ON, led_in=4'b1101 -> ch0 falls 15->0 while ch1 rises 0->15 concurrently; both end steady.
//   Mid-rise (duty=7) drive led_in[0]=1 -> ch0 turns FALLING from 7, reaches 0 after 7 step_ticks, no jump.
//   At duty=8 linear build: per 16-clock period led_out[0] low exactly 8 clocks; duty_act changes only at pwm_wrap.
//   Assert sys_rst_n=0 mid-fade -> led_out=4'b1111, fade_busy=0 asynchronously; with LED_GAMMA_EN duty=8 -> 4 clocks low.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and fade FSM encoding for the LED fade driver.
package led_pkg;

   localparam int LED_NUM = 4;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_RISING  = 2'd1,
      ST_ON      = 2'd2,
      ST_FALLING = 2'd3
   } fade_state_e;

endpackage

// File: rtl/led_fade_channel.sv
// One LED fade engine: direction FSM, saturating duty, period-aligned duty_act and PWM bit.
// LED_GAMMA_EN selects a squared (perceptual) compare instead of the linear one.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                target_on_i,
   input  logic                step_tick_i,
   input  logic                pwm_wrap_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic                led_o,
   output logic                busy_o
);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   fade_state_e         state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] duty_act_q;
   logic [PWM_BITS-1:0] compare;
   logic                led_q;

   // A change of target always wins over a pending step in the same cycle.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      case (state_q)
         ST_OFF: begin
            if (target_on_i) state_d = ST_RISING;
         end
         ST_RISING: begin
            if (!target_on_i)              state_d = ST_FALLING;
            else if (step_tick_i) begin
               if (duty_q == DUTY_MAX)     state_d = ST_ON;
               else                        duty_d  = duty_q + 1'b1;
            end
         end
         ST_ON: begin
            if (!target_on_i) state_d = ST_FALLING;
         end
         ST_FALLING: begin
            if (target_on_i)               state_d = ST_RISING;
            else if (step_tick_i) begin
               if (duty_q == '0)           state_d = ST_OFF;
               else                        duty_d  = duty_q - 1'b1;
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

`ifdef LED_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;
   assign duty_sq = {{PWM_BITS{1'b0}}, duty_act_q} * {{PWM_BITS{1'b0}}, duty_act_q};
   assign compare = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign compare = duty_act_q;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= ST_OFF;
         duty_q     <= '0;
         duty_act_q <= '0;
         led_q      <= 1'b1;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         // Only whole PWM periods are ever emitted with a given duty.
         if (pwm_wrap_i) duty_act_q <= duty_q;
         led_q   <= ~((duty_act_q == DUTY_MAX) | (pwm_cnt_i < compare));
      end
   end

   assign led_o  = led_q;
   assign busy_o = (state_q == ST_RISING) | (state_q == ST_FALLING);

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade post-processor for the 4-LED water-light chain: shared PWM/step timebase plus
// one fade channel per LED. Build option LED_GAMMA_EN (in led_fade_channel) enables gamma compare.
module led_fade_driver
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned STEP_CNT_MAX = 97_655
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [LED_NUM-1:0] led_in,
   output logic [LED_NUM-1:0] led_out,
   output logic               fade_busy
);
   localparam int unsigned STEP_W = (STEP_CNT_MAX > 0) ? $clog2(STEP_CNT_MAX + 1) : 1;

   logic [LED_NUM-1:0]  led_in_q;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic                step_tick, pwm_wrap;
   logic [LED_NUM-1:0]  ch_busy;
   logic                fade_busy_q;

   assign pwm_wrap   = (pwm_cnt_q == {PWM_BITS{1'b1}});
   assign step_tick  = (step_cnt_q == STEP_W'(STEP_CNT_MAX));
   assign step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         led_in_q    <= '1;
         pwm_cnt_q   <= '0;
         step_cnt_q  <= '0;
         fade_busy_q <= 1'b0;
      end else begin
         led_in_q    <= led_in;
         pwm_cnt_q   <= pwm_cnt_q + 1'b1;
         step_cnt_q  <= step_cnt_d;
         fade_busy_q <= |ch_busy;
      end
   end

   for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
      led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .target_on_i (~led_in_q[i]),
         .step_tick_i (step_tick),
         .pwm_wrap_i  (pwm_wrap),
         .pwm_cnt_i   (pwm_cnt_q),
         .led_o       (led_out[i]),
         .busy_o      (ch_busy[i])
      );
   end

   assign fade_busy = fade_busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4, STEP_CNT_MAX=3 (step every 4 clocks, period 16).
module tb_led_fade_driver;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [3:0] led_in    = 4'hF;
   logic [3:0] led_out;
   logic       fade_busy;

   int checks = 0;
   int errors = 0;

   led_fade_driver #(.PWM_BITS(4), .STEP_CNT_MAX(3)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .led_in    (led_in),
      .led_out   (led_out),
      .fade_busy (fade_busy)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [3:0] pat;
      logic       busy;
      logic [3:0] out;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reset released on a falling edge: the next rising edge is edge 1, with
   // step ticks on edges 4,8,.. and PWM wraps on edges 16,32,..
   task automatic reset_align(input logic [3:0] pat);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      led_in    = pat;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   // Sample after edges 1..80, counting led_out[0] low clocks per 16-clock window.
   task automatic fade_windows(input string tag, input int sw_n, input logic [3:0] sw_pat,
                               input int b0_n, input int b1_n,
                               input int e0, input int e1, input int e2, input int e3, input int e4);
      int lows[5];
      int exp_l[5];
      int side_bad;
      lows     = '{default: 0};
      exp_l    = '{e0, e1, e2, e3, e4};
      side_bad = 0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge sys_clk);
         if (!led_out[0]) lows[(n-1)/16]++;
         if (led_out[3:1] != 3'b111) side_bad++;
         if (n == b0_n) chk({tag, " busy_low"}, int'(fade_busy), 0);
         if (n == b1_n) chk({tag, " busy_high"}, int'(fade_busy), 1);
         if (n == sw_n) led_in = sw_pat;
      end
      for (int w = 0; w < 5; w++)
         chk($sformatf("%s window%0d low_clocks", tag, w), lows[w], exp_l[w]);
      chk({tag, " other_leds_off"}, side_bad, 0);
   endtask

   initial begin
      int dur;
      int bad;

      tbl[0] = '{pat: 4'b1110, busy: 1'b1, out: 4'b1110};
      tbl[1] = '{pat: 4'b1101, busy: 1'b1, out: 4'b1101};
      tbl[2] = '{pat: 4'b1101, busy: 1'b0, out: 4'b1101};
      tbl[3] = '{pat: 4'b0000, busy: 1'b1, out: 4'b0000};
      tbl[4] = '{pat: 4'b1010, busy: 1'b1, out: 4'b1010};
      tbl[5] = '{pat: 4'b0101, busy: 1'b1, out: 4'b0101};
      tbl[6] = '{pat: 4'b1111, busy: 1'b1, out: 4'b1111};

      // Reset state and idle hold
      @(negedge sys_clk);
      chk("reset led_out", int'(led_out), 15);
      chk("reset fade_busy", int'(fade_busy), 0);
      sys_rst_n = 1'b1;
      bad = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge sys_clk);
         if (led_out != 4'hF || fade_busy) bad++;
      end
      chk("idle 200 clocks bad", bad, 0);

      // Rise from reset, reverse at duty 7 (led_in_r changes on edge 29), fall back to 0 by edge 60
      reset_align(4'b1110);
`ifdef LED_GAMMA_EN
      fade_windows("reverse", 28, 4'b1111, 61, 60, 0, 0, 3, 0, 0);
`else
      fade_windows("reverse", 28, 4'b1111, 61, 60, 0, 3, 7, 3, 0);
`endif

      // Rise starting on edge 13 so duty_act is 4, 8, 12 on successive periods
      reset_align(4'b1111);
`ifdef LED_GAMMA_EN
      fade_windows("duty8", 11, 4'b1110, 13, 14, 0, 0, 1, 4, 9);
`else
      fade_windows("duty8", 11, 4'b1110, 13, 14, 0, 0, 4, 8, 12);
`endif

      // Steady-state pattern table
      reset_align(4'b1111);
      repeat (40) @(negedge sys_clk);
      for (int v = 0; v < 7; v++) begin
         @(negedge sys_clk);
         led_in = tbl[v].pat;
         repeat (2) @(negedge sys_clk);
         chk($sformatf("vec%0d busy_before", v), int'(fade_busy), 0);
         @(negedge sys_clk);
         chk($sformatf("vec%0d busy_start", v), int'(fade_busy), int'(tbl[v].busy));
         dur = 0;
         while (fade_busy && dur < 200) begin
            dur++;
            @(negedge sys_clk);
         end
         if (tbl[v].busy) chk_range($sformatf("vec%0d busy_clocks", v), dur, 61, 64);
         else             chk($sformatf("vec%0d busy_clocks", v), dur, 0);
         repeat (20) @(negedge sys_clk);
         bad = 0;
         for (int n = 0; n < 32; n++) begin
            @(negedge sys_clk);
            if (led_out != tbl[v].out || fade_busy) bad++;
         end
         chk($sformatf("vec%0d steady_bad", v), bad, 0);
      end

      // Asynchronous reset mid-fade while led_out[0] is lit
      reset_align(4'b1110);
      repeat (40) @(negedge sys_clk);
      chk("midfade busy", int'(fade_busy), 1);
      dur = 0;
      while (led_out[0] && dur < 32) begin
         dur++;
         @(negedge sys_clk);
      end
      chk("midfade led0 lit", int'(led_out[0]), 0);
      #1 sys_rst_n = 1'b0;
      led_in = 4'hF;
      #1;
      chk("async reset led_out", int'(led_out), 15);
      chk("async reset fade_busy", int'(fade_busy), 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      bad = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge sys_clk);
         if (led_out != 4'hF || fade_busy) bad++;
      end
      chk("post reset no memory", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
